// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_BIT_WIDTH = 8;

endpackage : serial_arith_pkg

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the serial arithmetic units.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    always_comb begin
        sum       = a ^ b ^ carry_in;
        carry_out = (a & b) | (a & carry_in) | (b & carry_in);
    end

endmodule : full_adder

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one full-adder cell.
// Subtraction is done as a + ~b + ~borrow_in; the final carry inverted is the borrow.
module serial_subtractor_nbit
    import serial_arith_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out
);

    localparam int CNT_W = $clog2(BIT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] a_sr_q, a_sr_d;
    logic [BIT_WIDTH-1:0] b_sr_q, b_sr_d;
    logic [BIT_WIDTH-1:0] res_q, res_d;
    logic [BIT_WIDTH-1:0] diff_q, diff_d;
    logic                 carry_q, carry_d;
    logic                 borrow_q, borrow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fa_sum, fa_cout;
    logic                 last_bit;

    full_adder u_fa (
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Datapath: start is only honoured in IDLE, so a held start cannot retrigger.
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = ~b;
                    carry_d = ~borrow_in;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end
            SHIFT: begin
                res_d   = {fa_sum, res_q[BIT_WIDTH-1:1]};
                carry_d = fa_cout;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                if (last_bit) begin
                    diff_d   = {fa_sum, res_q[BIT_WIDTH-1:1]};
                    borrow_d = ~fa_cout;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule : serial_subtractor_nbit

// File: tb/tb_serial_subtractor_nbit.sv
// Directed bench for serial_subtractor_nbit at widths 8 and 4.
module tb_serial_subtractor_nbit;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_nbit #(.BIT_WIDTH(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8),
        .borrow_in(bin8), .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bout8)
    );

    serial_subtractor_nbit #(.BIT_WIDTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .a(a4), .b(b4),
        .borrow_in(bin4), .busy(busy4), .done(done4), .diff(diff4),
        .borrow_out(bout4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic bin_v, input logic [7:0] exp_d, input logic exp_bo,
                        input bit check_busy);
        int lat;
        int busy_cnt;
        a8 = a_v; b8 = b_v; bin8 = bin_v; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'hxx; b8 = 8'hxx; bin8 = 1'bx;
        lat = 0;
        busy_cnt = busy8 ? 1 : 0;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
            if (busy8) busy_cnt++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_diff"}, 32'(diff8), 32'(exp_d));
        check({tag, "_bout"}, 32'(bout8), 32'(exp_bo));
        tick();
        check({tag, "_done_drop"}, 32'(done8), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy8), 32'd0);
        if (check_busy) check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        n_rst = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        n_rst = 1'b1;
        tick();

        run8("sub100_37", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b1);
        run8("sub0_1", 8'd0, 8'd1, 1'b0, 8'd255, 1'b1, 1'b0);
        run8("sub0_255_b", 8'd0, 8'd255, 1'b1, 8'd0, 1'b1, 1'b0);
        run8("sub255_0_b", 8'd255, 8'd0, 1'b1, 8'd254, 1'b0, 1'b0);

        // Held start: second op must launch only from the first IDLE cycle.
        a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'd9; b8 = 8'd3;
        dcount = 0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i <= 17 && done8) dcount++;
            if (i == 7) check("hold_prev_diff", 32'(diff8), 32'd254);
            if (i == 8) begin
                check("hold_done1", 32'(done8), 32'd1);
                check("hold_diff1", 32'(diff8), 32'd30);
            end
            if (i == 9) begin
                check("hold_idle_busy", 32'(busy8), 32'd0);
                check("hold_idle_done", 32'(done8), 32'd0);
            end
            if (i == 10) check("hold_restart_busy", 32'(busy8), 32'd1);
            if (i == 17) check("hold_no_early_done", 32'(done8), 32'd0);
            if (i == 18) begin
                check("hold_done2", 32'(done8), 32'd1);
                check("hold_diff2", 32'(diff8), 32'd6);
                check("hold_bout2", 32'(bout8), 32'd0);
            end
        end
        start8 = 1'b0;
        check("hold_single_done", 32'(dcount), 32'd1);
        tick();

        // Reset during the 4th SHIFT cycle aborts the operation.
        a8 = 8'd100; b8 = 8'd37; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_bout", 32'(bout8), 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) dcount++;
        end
        check("abort_quiet", 32'(dcount), 32'd0);
        run8("after_abort", 8'd200, 8'd201, 1'b0, 8'd255, 1'b1, 1'b1);

        // Exhaustive 4-bit sweep, back-to-back.
        for (int k = 0; k < 512; k++) begin
            int lat;
            int ea, eb, ebin, full;
            ea = k & 15; eb = (k >> 4) & 15; ebin = (k >> 8) & 1;
            full = ea - eb - ebin;
            a4 = 4'(ea); b4 = 4'(eb); bin4 = ebin[0]; start4 = 1'b1;
            tick();
            start4 = 1'b0;
            lat = 0;
            while (!done4 && lat < 12) begin
                tick();
                lat++;
            end
            check($sformatf("ex_lat_%0d", k), 32'(lat), 32'd4);
            check($sformatf("ex_diff_%0d", k), 32'(diff4), 32'(full & 15));
            check($sformatf("ex_bout_%0d", k), 32'(bout4), (full < 0) ? 32'd1 : 32'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor_nbit
